dl_sdram_writer: RTL
====================

DL_SDRAM_WRITER -- requirements
Module: dl_sdram_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered download words (power of two, 2..16).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 downloading  in  1  download-active level from the SPI file-transfer stage, already synchronous to clk.
REQ-005 dl_wr  in  1  one-cycle write strobe from the file-transfer stage.
REQ-006 dl_addr  in  25  word address for dl_data.
REQ-007 dl_data  in  16  download word.
REQ-008 sdram_req  out  1  write request to the SDRAM port.
REQ-009 sdram_addr  out  25  word address presented with sdram_req.
REQ-010 sdram_din  out  16  write data presented with sdram_req.
REQ-011 sdram_ack  in  1  one-cycle acceptance from the SDRAM port.
REQ-012 cpu_hold  out  1  keeps the CPU in reset while a download is in progress or not yet drained.
REQ-013 dl_done  out  1  one-cycle pulse when a download has fully reached SDRAM.
REQ-014 overflow  out  1  sticky flag: a download word was dropped.
REQ-015 word_count  out  25  words written to SDRAM in the current download.

Function
REQ-016 A dl_wr pulse SHALL push {dl_addr, dl_data} into the FIFO in the same cycle; the entry is visible at the FIFO head on the next cycle.
REQ-017 The state machine SHALL have states IDLE and REQ: IDLE->REQ when the FIFO is non-empty; REQ->IDLE on sdram_ack.
REQ-018 In REQ, sdram_req SHALL be high, with sdram_addr/sdram_din equal to the FIFO head and held stable until sdram_ack.
REQ-019 On sdram_ack in REQ, the head entry SHALL be popped and word_count incremented by 1 (modulo 2^25); sdram_req SHALL drop for at least one cycle (IDLE) before the next request.
REQ-020 sdram_ack outside REQ SHALL be ignored.
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged, and both operations SHALL take effect.
REQ-022 A push while full with no pop in that cycle SHALL be dropped, SHALL set overflow, and SHALL leave the FIFO contents unchanged.
REQ-023 A push while full with a pop in the same cycle SHALL be accepted; overflow SHALL NOT be set.
REQ-024 A rising edge of downloading SHALL clear overflow and word_count and set an internal pending flag; FIFO contents and any in-flight request SHALL be preserved.
REQ-025 cpu_hold SHALL be high when downloading=1, the FIFO is non-empty or state=REQ; otherwise low (combinational from registered state).
REQ-026 dl_done SHALL pulse for exactly one cycle when pending=1, downloading=0, the FIFO is empty and state=IDLE; pending SHALL clear in that cycle.
REQ-027 Empty/full SHALL be derived from read/write pointers with one extra wrap bit; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 While reset_n=0 at a clock edge: FIFO emptied, state=IDLE, sdram_req=0, sdram_addr=0, sdram_din=0, dl_done=0, overflow=0, word_count=0, pending=0, and the recorded previous value of downloading=0.
REQ-029 Reset asserted during REQ SHALL abandon the request with no pop; any late sdram_ack SHALL be ignored.

Structure
REQ-030 Shared package dl_pkg SHALL hold DL_ADDR_W=25, DL_DATA_W=16, the default FIFO depth and the state enum {IDLE, REQ}.
REQ-031 The FIFO SHALL be a sub-module dl_fifo (push, pop, full, empty, head data, synchronous active-low reset); the FSM, counter and flags SHALL be in dl_sdram_writer.

Verification
REQ-032 Single word: downloading 0->1, dl_wr with addr 0x800000, data 0xA55A, ack 3 cycles after req -> one req with 0x800000/0xA55A, word_count=1; after downloading drops, one dl_done pulse.
REQ-033 Burst: 4 back-to-back dl_wr with ack held low -> FIFO full, no overflow; a fifth dl_wr -> overflow=1 and that word never appears on sdram_addr.
REQ-034 Simultaneous: FIFO full, dl_wr in the same cycle as sdram_ack -> no overflow, FIFO order preserved, all words written in address order.
REQ-035 Reset mid-request: reset_n low for 1 cycle while sdram_req=1 -> sdram_req=0, cpu_hold=0, word_count=0; an ack 1 cycle later is ignored.
REQ-036 New download: overflow=1 from a prior run; downloading rises -> overflow=0, word_count=0; 0x900000..0x900003 written -> word_count=4.

Source files
------------

// File: rtl/dl_pkg.sv
// Shared widths, default FIFO depth and types for the download
// path from the SPI file-transfer stage into SDRAM.
package dl_pkg;

  localparam int DL_ADDR_W     = 25;
  localparam int DL_DATA_W     = 16;
  localparam int DL_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } dl_state_t;

  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [DL_DATA_W-1:0] data;
  } dl_word_t;

endpackage

// File: rtl/dl_fifo.sv
// Small download-word FIFO; pointers carry one extra wrap bit so
// full and empty can be told apart when the low bits match.
module dl_fifo
  import dl_pkg::*;
#(
  parameter int DEPTH = DL_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  dl_word_t din,
  output logic     full,
  output logic     empty,
  output dl_word_t head
);

  localparam int AW = $clog2(DEPTH);

  dl_word_t mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic do_push;
  logic do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO
  // still takes a push when the head leaves.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dl_sdram_writer.sv
// Buffers download words and replays them as single SDRAM write
// requests, holding the CPU in reset until everything has landed.
module dl_sdram_writer
  import dl_pkg::*;
#(
  parameter int FIFO_DEPTH = DL_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 downloading,
  input  logic                 dl_wr,
  input  logic [DL_ADDR_W-1:0] dl_addr,
  input  logic [DL_DATA_W-1:0] dl_data,
  output logic                 sdram_req,
  output logic [DL_ADDR_W-1:0] sdram_addr,
  output logic [DL_DATA_W-1:0] sdram_din,
  input  logic                 sdram_ack,
  output logic                 cpu_hold,
  output logic                 dl_done,
  output logic                 overflow,
  output logic [DL_ADDR_W-1:0] word_count
);

  dl_state_t state;
  dl_state_t state_nxt;
  dl_word_t  din;
  dl_word_t  head;
  logic      full;
  logic      empty;
  logic      pop;
  logic      drop;
  logic      dl_prev;
  logic      dl_rise;
  logic      pending;

  assign din = '{addr: dl_addr, data: dl_data};

  dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (dl_wr),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!empty)   state_nxt = REQ;
      REQ:  if (sdram_ack) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdram_req  = 1'b0;
    sdram_addr = '0;
    sdram_din  = '0;
    pop        = 1'b0;
    if (state == REQ) begin
      sdram_req  = 1'b1;
      sdram_addr = head.addr;
      sdram_din  = head.data;
      pop        = sdram_ack;
    end
  end

  assign dl_rise  = downloading && !dl_prev;
  assign drop     = dl_wr && full && !pop;
  assign cpu_hold = downloading || !empty || (state == REQ);
  assign dl_done  = pending && !downloading &&
                    empty && (state == IDLE);

  // A drop in the very cycle a new download starts still counts
  // against the new download, so it wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dl_prev    <= 1'b0;
      pending    <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      dl_prev <= downloading;
      if (dl_rise)      pending <= 1'b1;
      else if (dl_done) pending <= 1'b0;
      if (drop)         overflow <= 1'b1;
      else if (dl_rise) overflow <= 1'b0;
      if (dl_rise)  word_count <= '0;
      else if (pop) word_count <= word_count + DL_ADDR_W'(1);
    end
  end

endmodule
